// File: rtl/uart_rx_pkg.sv
// Shared types and default timing for the UART receive frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_BIT_CYCLES = 10416;
  localparam int DEF_GUARD      = 5208;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to the idle-high line level.
module rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame controller: start detection, LSB-first data shift,
// parity/stop check, one-cycle data_valid strobe with error flags.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARITY_ODD = 0,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int GUARD      = DEF_GUARD
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  input  logic                 check_i,
  input  logic                 clk_2_i,
  output logic                 possible_start_o,
  output logic                 write_char_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 parity_error_o,
  output logic                 frame_error_o
);

  localparam int  CW   = $clog2(BIT_CYCLES + 1);
  localparam int  BW   = $clog2(DATA_BITS + 1);
  localparam bit  PODD = (PARITY_ODD != 0);

  rx_state_e            state_q;
  logic                 clk_2_prev_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [CW-1:0]        guard_cnt_q;
  logic [CW-1:0]        stop_cnt_q;
  logic                 par_err_q;
  logic                 possible_start_q;
  logic                 write_char_q;
  logic                 data_valid_q;
  logic                 parity_error_q;
  logic                 frame_error_q;
  logic                 rx_s;
  logic                 rise;

  rx_sync #(.WIDTH(1)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  assign rise = clk_2_i & ~clk_2_prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      clk_2_prev_q     <= 1'b0;
      shift_q          <= '0;
      data_q           <= '0;
      bit_cnt_q        <= '0;
      guard_cnt_q      <= '0;
      stop_cnt_q       <= '0;
      par_err_q        <= 1'b0;
      possible_start_q <= 1'b0;
      write_char_q     <= 1'b0;
      data_valid_q     <= 1'b0;
      parity_error_q   <= 1'b0;
      frame_error_q    <= 1'b0;
    end else begin
      clk_2_prev_q   <= clk_2_i;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q          <= START;
            possible_start_q <= 1'b1;
          end
        end
        // clk_2 edges are ignored here; only the midpoint check decides
        START: begin
          if (check_i) begin
            possible_start_q <= 1'b0;
            if (!rx_s) begin
              state_q      <= DATA;
              write_char_q <= 1'b1;
              bit_cnt_q    <= '0;
              guard_cnt_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (guard_cnt_q < CW'(GUARD)) begin
            guard_cnt_q <= guard_cnt_q + CW'(1);
          end else if (rise) begin
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
              state_q      <= PARITY;
              write_char_q <= 1'b0;
            end
          end
        end
        PARITY: begin
          if (rise) begin
            par_err_q  <= (^shift_q) ^ rx_s ^ PODD;
            state_q    <= STOP;
            stop_cnt_q <= '0;
          end
        end
        STOP: begin
          if (stop_cnt_q == CW'(BIT_CYCLES - 1)) begin
            frame_error_q  <= ~rx_s;
            parity_error_q <= par_err_q;
            data_q         <= shift_q;
            data_valid_q   <= 1'b1;
            state_q        <= IDLE;
          end else begin
            stop_cnt_q <= stop_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q          <= IDLE;
          possible_start_q <= 1'b0;
          write_char_q     <= 1'b0;
        end
      endcase
    end
  end

  assign possible_start_o = possible_start_q;
  assign write_char_o     = write_char_q;
  assign data_o           = data_q;
  assign data_valid_o     = data_valid_q;
  assign parity_error_o   = parity_error_q;
  assign frame_error_o    = frame_error_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a behavioural bit-timing stage driving check/clk_2.
module tb_uart_rx_frame;

  localparam int B = 256;
  localparam int G = 128;

  logic       clk = 1'b0;
  logic       reset, rx, check, clk_2;
  logic       possible_start, write_char, data_valid, parity_error, frame_error;
  logic [7:0] data;

  int         total = 0;
  int         bad   = 0;
  int         nstrobe;
  int         dv_run, dv_maxrun;
  bit         wc_seen;
  logic [7:0] caps[$];
  logic       cap_pe, cap_fe;

  uart_rx_frame #(
    .DATA_BITS(8), .PARITY_ODD(0), .BIT_CYCLES(B), .GUARD(G)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .rx_i             (rx),
    .check_i          (check),
    .clk_2_i          (clk_2),
    .possible_start_o (possible_start),
    .write_char_o     (write_char),
    .data_o           (data),
    .data_valid_o     (data_valid),
    .parity_error_o   (parity_error),
    .frame_error_o    (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (data_valid === 1'b1) begin
      nstrobe++;
      caps.push_back(data);
      cap_pe = parity_error;
      cap_fe = frame_error;
      dv_run++;
      if (dv_run > dv_maxrun) dv_maxrun = dv_run;
    end else begin
      dv_run = 0;
    end
    if (write_char === 1'b1) wc_seen = 1'b1;
  endtask

  task automatic clear_mon();
    nstrobe   = 0;
    dv_run    = 0;
    dv_maxrun = 0;
    wc_seen   = 1'b0;
    caps.delete();
  endtask

  // Serial frame plus timing-stage model: check at start-bit midpoint,
  // clk_2 rising at every following bit midpoint (first rise coincides with check).
  task automatic send(input logic [7:0] d, input bit par_flip, input bit stop_v, input int ncyc);
    logic [10:0] bits;
    bits = {stop_v, (^d) ^ par_flip, d, 1'b0};
    for (int t = 0; t < ncyc; t++) begin
      rx    = bits[t / B];
      check = (t == B / 2);
      clk_2 = (t >= B / 2) && (((t - B / 2) % B) < B / 2);
      tick();
    end
    rx    = 1'b1;
    check = 1'b0;
    clk_2 = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; check = 1'b0; clk_2 = 1'b0;
    clear_mon();
    idle(2);
    reset = 1'b0;
    chk("rst_data", data, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_ps", possible_start, 1'b0);
    chk("rst_wc", write_char, 1'b0);
    chk("rst_pe", parity_error, 1'b0);
    chk("rst_fe", frame_error, 1'b0);
    idle(5);

    // 0x55 clean frame
    clear_mon();
    send(8'h55, 1'b0, 1'b1, 11 * B);
    idle(4);
    chk("f55_cnt", nstrobe, 1);
    chk("f55_data", caps[0], 8'h55);
    chk("f55_pe", cap_pe, 1'b0);
    chk("f55_fe", cap_fe, 1'b0);
    chk("f55_width", dv_maxrun, 1);
    chk("f55_wc", wc_seen, 1'b1);

    // 0xA3 with inverted parity bit
    clear_mon();
    send(8'hA3, 1'b1, 1'b1, 11 * B);
    idle(4);
    chk("fA3_cnt", nstrobe, 1);
    chk("fA3_data", caps[0], 8'hA3);
    chk("fA3_pe", cap_pe, 1'b1);
    chk("fA3_fe", cap_fe, 1'b0);
    chk("fA3_hold", data, 8'hA3);
    chk("fA3_peclr", parity_error, 1'b0);

    // 0x0F with stop bit low
    clear_mon();
    send(8'h0F, 1'b0, 1'b0, 11 * B);
    idle(2);
    chk("f0F_cnt", nstrobe, 1);
    chk("f0F_data", caps[0], 8'h0F);
    chk("f0F_fe", cap_fe, 1'b1);
    chk("f0F_pe", cap_pe, 1'b0);
    chk("f0F_feclr", frame_error, 1'b0);
    pulse_reset();
    chk("rst2_data", data, 8'h00);
    chk("rst2_ps", possible_start, 1'b0);
    idle(5);

    // Start glitch: rx low 100 cycles, high again before check
    clear_mon();
    for (int t = 0; t < B / 2; t++) begin
      rx = (t < 100) ? 1'b0 : 1'b1;
      tick();
      if (t == 99) chk("gl_ps_up", possible_start, 1'b1);
    end
    check = 1'b1;
    tick();
    check = 1'b0;
    idle(B);
    chk("gl_ps_down", possible_start, 1'b0);
    chk("gl_cnt", nstrobe, 0);
    chk("gl_wc", wc_seen, 1'b0);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x3C
    clear_mon();
    send(8'hFF, 1'b0, 1'b1, 5 * B + B / 2);
    chk("abort_wc_pre", write_char, 1'b1);
    pulse_reset();
    chk("abort_wc", write_char, 1'b0);
    chk("abort_ps", possible_start, 1'b0);
    idle(2 * B);
    send(8'h3C, 1'b0, 1'b1, 11 * B);
    idle(4);
    chk("f3C_cnt", nstrobe, 1);
    chk("f3C_data", caps[0], 8'h3C);
    chk("f3C_pe", cap_pe, 1'b0);
    chk("f3C_fe", cap_fe, 1'b0);

    // Back-to-back frames, no idle gap
    clear_mon();
    send(8'h12, 1'b0, 1'b1, 11 * B);
    send(8'h34, 1'b0, 1'b1, 11 * B);
    idle(4);
    chk("b2b_cnt", nstrobe, 2);
    chk("b2b_first", (caps.size() > 0) ? caps[0] : 8'hxx, 8'h12);
    chk("b2b_second", (caps.size() > 1) ? caps[1] : 8'hxx, 8'h34);
    chk("b2b_hold", data, 8'h34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
